// File: rtl/rcc_div_ctrl.sv
// rcc_div_ctrl: glitch-free reprogramming sequencer for the RCC clock divider
module rcc_div_ctrl #(
    parameter int WIDTH       = 6,
    parameter int RESET_RATIO = 2,
    parameter int GATE_CYC    = 4,
    parameter int RST_CYC     = 2,
    parameter int SETTLE_MULT = 2
) (
    input  logic             REF_CLK,
    input  logic             RST,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_ratio,
    output logic             req_ready,
    output logic [WIDTH-1:0] div_ratio,
    output logic             div_rst_n,
    output logic             clk_gate_en,
    output logic             busy,
    output logic             done
);
    localparam int CW = WIDTH + 3;

    typedef enum logic [1:0] {IDLE, GATE, HOLD, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             init_q, init_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic             rst_n_q, rst_n_d;
    logic             gate_q, gate_d;
    logic             done_q, done_d;
    logic [CW-1:0]    settle;
    logic             accept;

    assign settle      = CW'(SETTLE_MULT) * ((ratio_q > WIDTH'(1)) ? CW'(ratio_q) : CW'(1));
    assign req_ready   = (state_q == IDLE) && !RST;
    assign busy        = state_q != IDLE;
    assign accept      = req_valid && req_ready;
    assign div_ratio   = ratio_q;
    assign div_rst_n   = rst_n_q;
    assign clk_gate_en = gate_q;
    assign done        = done_q;

    // sequence gate -> hold divider in reset with new ratio -> release -> settle -> ungate
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        pend_d  = accept ? req_ratio : pend_q;
        ratio_d = ratio_q;
        rst_n_d = rst_n_q;
        gate_d  = gate_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && req_ratio == ratio_q) begin
                    done_d = 1'b1;
                end else if (accept) begin
                    state_d = GATE;
                    gate_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            GATE: begin
                if (cnt_q == CW'(GATE_CYC - 1)) begin
                    state_d = HOLD;
                    rst_n_d = 1'b0;
                    ratio_d = pend_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    state_d = RELEASE;
                    rst_n_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == settle - CW'(1)) begin
                    state_d = IDLE;
                    gate_d  = 1'b1;
                    cnt_d   = '0;
                    done_d  = !init_q;
                    init_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // register all state; reset restarts the init load of RESET_RATIO from the divider-reset phase
    always_ff @(posedge REF_CLK) begin
        if (RST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            init_q  <= 1'b1;
            pend_q  <= WIDTH'(RESET_RATIO);
            ratio_q <= WIDTH'(RESET_RATIO);
            rst_n_q <= 1'b0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            pend_q  <= pend_d;
            ratio_q <= ratio_d;
            rst_n_q <= rst_n_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_rcc_div_ctrl.sv
// tb_rcc_div_ctrl: randomized scoreboard bench for the divider reprogramming sequencer
module tb_rcc_div_ctrl;
    localparam int W  = 6;
    localparam int RR = 2;
    localparam int G  = 4;
    localparam int R  = 2;
    localparam int SM = 2;

    typedef struct {
        int c;
        int r;
    } exp_t;

    logic         REF_CLK = 1'b0;
    logic         RST = 1'b1;
    logic         req_valid = 1'b0;
    logic [W-1:0] req_ratio = '0;
    logic         req_ready, div_rst_n, clk_gate_en, busy, done;
    logic [W-1:0] div_ratio;

    int   cyc = 0, n_cmp = 0, n_err = 0;
    bit   chk_en = 0, last_acc = 0;
    int   seq_start = 0, seq_old = RR, seq_new = RR, m_ratio = RR;
    exp_t sbq[$];

    rcc_div_ctrl #(.WIDTH(W), .RESET_RATIO(RR), .GATE_CYC(G), .RST_CYC(R), .SETTLE_MULT(SM)) dut (
        .REF_CLK(REF_CLK), .RST(RST), .req_valid(req_valid), .req_ratio(req_ratio),
        .req_ready(req_ready), .div_ratio(div_ratio), .div_rst_n(div_rst_n),
        .clk_gate_en(clk_gate_en), .busy(busy), .done(done)
    );

    always #5 REF_CLK = ~REF_CLK;

    function automatic int settle(int r);
        return SM * (r > 1 ? r : 1);
    endfunction

    function automatic bit exp_busy(int c);
        return (c - seq_start) < G + R + settle(seq_new);
    endfunction

    task automatic chk(string n, int a, int e);
        n_cmp++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", n, cyc, a, e);
        end
    endtask

    // one clock of stimulus; the model advances on the edge that samples these inputs
    task automatic step(input bit r, input bit v, input int d);
        bit acc;
        RST       = r;
        req_valid = v;
        req_ratio = W'(d);
        acc = v && !r && !exp_busy(cyc);
        @(posedge REF_CLK);
        cyc++;
        last_acc = acc;
        if (r) begin
            seq_start = cyc - G;
            seq_old   = RR;
            seq_new   = RR;
            m_ratio   = RR;
            sbq.delete();
            chk_en    = 1;
        end else if (acc) begin
            if (d == m_ratio) begin
                sbq.push_back(exp_t'{cyc, d});
            end else begin
                seq_start = cyc;
                seq_old   = m_ratio;
                seq_new   = d;
                m_ratio   = d;
                sbq.push_back(exp_t'{cyc + G + R + settle(d), d});
            end
        end
        #2;
    endtask

    task automatic req(input int d);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            step(0, 1, d);
            if (last_acc) begin
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", int'(ok), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!exp_busy(cyc)) break;
            step(0, 0, 0);
        end
    endtask

    // monitor: timeline model of the outputs plus done scoreboard
    always @(negedge REF_CLK) begin
        int   t;
        bit   b;
        exp_t e;
        if (chk_en) begin
            t = cyc - seq_start;
            b = t < G + R + settle(seq_new);
            chk("div_ratio", int'(div_ratio), t < G ? seq_old : seq_new);
            chk("div_rst_n", int'(div_rst_n), (t >= G && t < G + R) ? 0 : 1);
            chk("clk_gate_en", int'(clk_gate_en), b ? 0 : 1);
            chk("busy", int'(busy), int'(b));
            chk("req_ready", int'(req_ready), int'(!b && !RST));
            if (sbq.size() > 0 && sbq[0].c == cyc) begin
                e = sbq.pop_front();
                chk("done", int'(done), 1);
                chk("done_ratio", int'(div_ratio), e.r);
            end else begin
                chk("done", int'(done), 0);
            end
        end
    end

    initial begin
        repeat (3) step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        req(6);
        step(0, 0, 0);
        wait_idle();
        req(6);
        repeat (2) step(0, 0, 0);
        req(2);
        req(3);
        step(0, 0, 0);
        wait_idle();
        req(5);
        repeat (G + R + 3) step(0, 0, 0);
        repeat (2) step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        req(0);
        step(0, 0, 0);
        wait_idle();
        for (int i = 0; i < 400; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? m_ratio : int'($urandom_range(0, 63));
            step($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, d);
        end
        step(0, 0, 0);
        wait_idle();
        repeat (3) step(0, 0, 0);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
